alu_exec_unit: RTL and testbench

//  Execute-stage unit: decodes ALUOp/funct3/funct7 into an internal op code and computes the result.

---
 rtl/alu_exec_unit_pkg.sv | 47 ++++
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_exec_unit_decode.sv | 32 +++
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: op codes, ALUOp/funct7 encodings and decode lookup helpers
package alu_exec_unit_pkg;

    localparam int OPC_W = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

    function automatic op_e m_op(input logic [2:0] f3);
        case (f3)
            3'b000:  m_op = OP_MUL;
            3'b001:  m_op = OP_MULH;
            3'b010:  m_op = OP_MULHSU;
            3'b011:  m_op = OP_MULHU;
            3'b100:  m_op = OP_DIV;
            3'b101:  m_op = OP_DIVU;
            3'b110:  m_op = OP_REM;
            default: m_op = OP_REMU;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: ID/EX-side operand handshake and EX/MEM-side result handshake
interface alu_exec_unit_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            busy;

    modport master (
        output flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, illegal, busy
    );

    modport slave (
        input  flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, illegal, busy
    );
endinterface

// File: rtl/alu_exec_unit_decode.sv
// alu_exec_unit_decode: maps ALUOp/funct3/funct7 onto an internal op code
module alu_exec_unit_decode import alu_exec_unit_pkg::*; #(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output op_e        op_o,
    output logic       illegal_o
);

    // I-type ignores funct7 except for shifts, where it selects logical/arithmetic
    always_comb begin
        op_o = OP_ILLEGAL;
        if (alu_op_i == ALUOP_ADD) op_o = OP_ADD;
        else if (alu_op_i == ALUOP_SUB) op_o = OP_SUB;
        else if (alu_op_i == ALUOP_R) begin
            if (funct7_i == F7_BASE) op_o = base_op(funct3_i);
            else if (funct7_i == F7_ALT && funct3_i == 3'b000) op_o = OP_SUB;
            else if (funct7_i == F7_ALT && funct3_i == 3'b101) op_o = OP_SRA;
            else if (funct7_i == F7_MULDIV && EN_M) op_o = m_op(funct3_i);
        end else if (funct3_i == 3'b001) begin
            if (funct7_i == F7_BASE) op_o = OP_SLL;
        end else if (funct3_i == 3'b101) begin
            if (funct7_i == F7_BASE) op_o = OP_SRL;
            else if (funct7_i == F7_ALT) op_o = OP_SRA;
        end else op_o = base_op(funct3_i);
    end

    assign illegal_o = op_o == OP_ILLEGAL;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU with iterative shift-add multiply and restoring divide
module alu_exec_unit import alu_exec_unit_pkg::*; #(
    parameter int XLEN  = 32,
    parameter bit EN_M  = 1'b1,
    parameter int CTL_W = OPC_W
) (
    input logic           clk,
    input logic           rst,
    alu_exec_unit_if.slave bus_io
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    op_e               dec_op;
    logic              dec_ill;
    state_e            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mc_q, mc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [CTL_W-1:0]  op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d, valid_q, valid_d;

    logic [XLEN-1:0]   a, b, mag_a, mag_b, alu_res, quo, rem, fin;
    logic [SW-1:0]     sh;
    logic              in_ready, accept, is_mul, is_div, sgn_a, sgn_b;
    logic              div_zero, div_ovf, div_fast, div_quo, lo_sel;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_iter, div_iter, iter, prod;

    alu_exec_unit_decode #(.EN_M(EN_M)) u_decode (
        .alu_op_i  (bus_io.alu_op),
        .funct3_i  (bus_io.funct3),
        .funct7_i  (bus_io.funct7),
        .op_o      (dec_op),
        .illegal_o (dec_ill)
    );

    assign a        = bus_io.op_a;
    assign b        = bus_io.op_b;
    assign sh       = b[SW-1:0];
    assign in_ready = state_q == ST_IDLE && (!valid_q || bus_io.out_ready) && !bus_io.flush;
    assign accept   = bus_io.in_valid && in_ready;

    assign is_mul   = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div   = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign sgn_a    = a[XLEN-1] && dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign sgn_b    = b[XLEN-1] && dec_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign mag_a    = sgn_a ? -a : a;
    assign mag_b    = sgn_b ? -b : b;
    assign div_zero = b == '0;
    assign div_ovf  = dec_op inside {OP_DIV, OP_REM} && a == MIN_NEG && b == '1;
    assign div_fast = is_div && (div_zero || div_ovf);
    assign div_quo  = dec_op inside {OP_DIV, OP_DIVU};

    // single-cycle results; divide-by-zero and signed overflow resolve here without iterating
    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << sh;
            OP_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: alu_res = XLEN'(a < b);
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = div_fast ? (div_quo ? (div_zero ? '1 : a) : (div_zero ? a : '0)) : '0;
        endcase
    end

    // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
    assign mul_iter = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, mc_q};
    assign div_iter = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign iter     = state_q == ST_DIV ? div_iter : mul_iter;

    // sign fix-up applied to the final iteration's value so the result loads on the counter==0 edge
    assign prod   = neg_q ? -iter : iter;
    assign quo    = iter[XLEN-1:0];
    assign rem    = iter[2*XLEN-1:XLEN];
    assign lo_sel = op_q == CTL_W'(OP_MUL) || op_q == CTL_W'(OP_DIV) || op_q == CTL_W'(OP_DIVU);
    assign fin    = state_q == ST_DIV ? (lo_sel ? (neg_q ? -quo : quo) : (rneg_q ? -rem : rem))
                                      : (lo_sel ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    // next-state: accept/launch in IDLE, one iteration per cycle in MUL/DIV, flush overrides all
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        op_d      = op_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        valid_d   = valid_q && !bus_io.out_ready;
        if (bus_io.flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept && (is_mul || is_div) && !div_fast) begin
                state_d = is_mul ? ST_MUL : ST_DIV;
                cnt_d   = SW'(XLEN - 1);
                acc_d   = {{XLEN{1'b0}}, is_mul ? mag_b : mag_a};
                mc_d    = is_mul ? mag_a : mag_b;
                neg_d   = sgn_a ^ sgn_b;
                rneg_d  = sgn_a;
                op_d    = CTL_W'(dec_op);
            end else if (accept) begin
                result_d  = alu_res;
                illegal_d = dec_ill;
                valid_d   = 1'b1;
            end
        end else begin
            acc_d = iter;
            cnt_d = cnt_q - SW'(1);
            if (cnt_q == '0) begin
                state_d   = ST_IDLE;
                result_d  = fin;
                illegal_d = 1'b0;
                valid_d   = 1'b1;
            end
        end
    end

    // state and datapath registers; reset discards any partial product/remainder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mc_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            op_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            op_q      <= op_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = valid_q;
    assign bus_io.result    = result_q;
    assign bus_io.illegal   = illegal_q;
    assign bus_io.busy      = state_q != ST_IDLE;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus handshake, M-op, flush and reset sequences
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus();

    alu_exec_unit #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t tv[$];
    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] res, input logic ill);
        tv.push_back('{op, f3, f7, a, b, res, ill});
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.op_a   = a;
        bus.op_b   = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_m(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int bsy;
        logic rdy;
        drive(2'b10, f3, 7'b0000001, a, b);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        bsy = 0;
        rdy = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            bsy += int'(bus.busy);
            rdy |= bus.in_ready;
            step();
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'd33);
        check({nm, " busy cycles"}, 32'(bsy), 32'd32);
        check({nm, " in_ready while busy"}, {31'b0, rdy}, 32'd0);
        check({nm, " result"}, bus.result, exp);
        check({nm, " illegal"}, {31'b0, bus.illegal}, 32'd0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 3'b000, 7'h00, 32'h0, 32'h0);

        add(2'b10, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0);
        add(2'b11, 3'b000, 7'h20, 32'd10,       32'd3,        32'd13,       1'b0);
        add(2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0);
        add(2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0);
        add(2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0);
        add(2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0);
        add(2'b01, 3'b000, 7'h00, 32'd10,       32'd3,        32'd7,        1'b0);
        add(2'b00, 3'b010, 7'h7F, 32'd100,      32'hFFFFFFFF, 32'd99,       1'b0);
        add(2'b10, 3'b000, 7'h20, 32'd3,        32'd10,       32'hFFFFFFF9, 1'b0);
        add(2'b10, 3'b001, 7'h00, 32'd1,        32'h25,       32'h20,       1'b0);
        add(2'b10, 3'b100, 7'h00, 32'hF0F0,     32'h0FF0,     32'hFF00,     1'b0);
        add(2'b10, 3'b110, 7'h00, 32'hF000,     32'h000F,     32'hF00F,     1'b0);
        add(2'b10, 3'b111, 7'h00, 32'hFF00,     32'h0F0F,     32'h0F00,     1'b0);
        add(2'b10, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0);
        add(2'b11, 3'b010, 7'h7F, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'd1,        1'b0);
        add(2'b11, 3'b101, 7'h20, 32'h80000000, 32'h00000401, 32'hC0000000, 1'b0);
        add(2'b11, 3'b001, 7'h00, 32'd3,        32'd2,        32'd12,       1'b0);
        add(2'b10, 3'b001, 7'h20, 32'd1,        32'd1,        32'd0,        1'b1);
        add(2'b10, 3'b000, 7'h02, 32'd1,        32'd1,        32'd0,        1'b1);
        add(2'b11, 3'b001, 7'h20, 32'd1,        32'd1,        32'd0,        1'b1);
        add(2'b11, 3'b101, 7'h01, 32'd1,        32'd1,        32'd0,        1'b1);
        add(2'b10, 3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0);
        add(2'b10, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        1'b0);
        add(2'b10, 3'b101, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0);
        add(2'b10, 3'b111, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0);
        add(2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        add(2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);

        repeat (2) step();
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset illegal", {31'b0, bus.illegal}, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", {31'b0, bus.in_ready}, 32'd1);

        foreach (tv[i]) begin
            drive(tv[i].op, tv[i].f3, tv[i].f7, tv[i].a, tv[i].b);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d result", i), bus.result, tv[i].res);
            check($sformatf("vec%0d illegal", i), {31'b0, bus.illegal}, {31'b0, tv[i].ill});
        end
        step();
        check("out_valid drops after consume", {31'b0, bus.out_valid}, 32'd0);

        run_m("MULH -2*3", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        run_m("MUL -2*3", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA);
        run_m("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_m("MULHSU", 3'b010, 32'd2, 32'h80000000, 32'd1);
        run_m("MULH 2*min", 3'b001, 32'd2, 32'h80000000, 32'hFFFFFFFF);
        run_m("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_m("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_m("DIV 7/-2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_m("REM 7/-2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1);
        run_m("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
        run_m("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2);

        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        bus.in_valid = 1'b1;
        step();
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 32'd100, 32'd200);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d out_valid", k), {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("stall%0d result", k), bus.result, 32'd3);
            check($sformatf("stall%0d in_ready", k), {31'b0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("in_ready on out_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("back-to-back result", bus.result, 32'd300);
        check("back-to-back out_valid", {31'b0, bus.out_valid}, 32'd1);
        step();

        drive(2'b00, 3'b000, 7'h00, 32'd4, 32'd4);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        check("held before flush", {31'b0, bus.out_valid}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("in_ready during flush", {31'b0, bus.in_ready}, 32'd0);
        step();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        check("held result flushed", {31'b0, bus.out_valid}, 32'd0);

        drive(2'b10, 3'b001, 7'b0000001, 32'hFFFFFFFE, 32'd3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        check("busy before flush", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
        bus.in_valid = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("busy after flush", {31'b0, bus.busy}, 32'd0);
        check("no accept during flush", {31'b0, bus.out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            step();
            seen |= bus.out_valid;
        end
        check("flushed MUL never valid", {31'b0, seen}, 32'd0);
        check("in_ready after flush", {31'b0, bus.in_ready}, 32'd1);

        drive(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        check("busy before reset", {31'b0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("busy async reset", {31'b0, bus.busy}, 32'd0);
        check("out_valid async reset", {31'b0, bus.out_valid}, 32'd0);
        check("result async reset", bus.result, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("in_ready after mid-op reset", {31'b0, bus.in_ready}, 32'd1);
        run_m("DIVU after reset", 3'b101, 32'd100, 32'd7, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
